tick_sequencer: RTL and testbench
=================================

TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 8, SHALL set steps per sequence; legal range 2..16.
REQ-002 Parameter WDOG_CYCLES, default 4194304, SHALL set the watchdog limit in clocks; used only with SEQ_WDOG_EN.
REQ-003 CLK  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 RST_N  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 GO  input  1  SHALL be a one-cycle request to start a sequence.
REQ-006 ABORT  input  1  SHALL be a one-cycle request to cancel the sequence.
REQ-007 LOOP  input  1  SHALL, when high at the last step, make the sequence wrap instead of finishing.
REQ-008 TICK  input  1  SHALL be the one-cycle expiry pulse from the upstream interval timer (its PULSE).
REQ-009 START_TMR  output  1  SHALL be the one-cycle arm request to the interval timer (its START_TMR).
REQ-010 STEP  output  4  SHALL be the current step index.
REQ-011 STEP_PULSE  output  1  SHALL be a one-cycle strobe on each step advance.
REQ-012 DONE  output  1  SHALL be a one-cycle strobe on normal sequence completion.
REQ-013 BUSY  output  1  SHALL be high while the state is not SEQ_IDLE_S.
REQ-014 ERR  output  1  SHALL be the sticky watchdog error flag.

Function
REQ-015 States SHALL be SEQ_IDLE_S, SEQ_ARM_S and SEQ_WAIT_S; any other encoding SHALL go to SEQ_IDLE_S on the next clock.
REQ-016 All outputs SHALL be registered; START_TMR, STEP_PULSE and DONE SHALL default low every cycle.
REQ-017 IDLE: GO high in cycle n, ABORT low -> STEP=0, START_TMR=1 and BUSY=1 in cycle n+1, state SEQ_WAIT_S.
REQ-018 WAIT: TICK high in cycle m with STEP<NUM_STEPS-1 -> STEP+1, STEP_PULSE=1 and START_TMR=1 in cycle m+1, staying in WAIT.
REQ-019 WAIT: TICK at STEP=NUM_STEPS-1 with LOOP high -> STEP=0, STEP_PULSE=1 and START_TMR=1 in cycle m+1.
REQ-020 WAIT: TICK at STEP=NUM_STEPS-1 with LOOP low -> STEP=0 and DONE=1 in cycle m+1, START_TMR stays low, state goes to IDLE.
REQ-021 SEQ_ARM_S SHALL be a one-cycle re-arm state used only when GO arrives in the same cycle as DONE is issued: START_TMR=1, then WAIT.
REQ-022 GO SHALL be ignored in WAIT; TICK SHALL be ignored in IDLE, covering a stray expiry after ABORT.
REQ-023 ABORT in any state -> IDLE and STEP=0 next cycle, no DONE and no STEP_PULSE; ABORT SHALL win over a simultaneous TICK or GO.
REQ-024 STEP arithmetic SHALL be 4-bit unsigned and SHALL never exceed NUM_STEPS-1.

Reset
REQ-025 While RST_N is low: state SEQ_IDLE_S, STEP=0, all 1-bit outputs 0, watchdog counter 0.
REQ-026 Reset asserted mid-sequence SHALL clear everything immediately; after release, no START_TMR SHALL be issued until a new GO.

Configuration
REQ-027 Macro SEQ_WDOG_EN defined: a counter of consecutive WAIT cycles without TICK, reaching WDOG_CYCLES -> ERR=1 (sticky until reset or the next accepted GO), STEP=0, state IDLE.
REQ-028 Macro SEQ_WDOG_EN undefined: no watchdog counter SHALL be built and ERR SHALL be tied to 0.

Structure
REQ-029 State encodings SEQ_IDLE_S, SEQ_ARM_S, SEQ_WAIT_S (2-bit) SHALL live in the shared constants.vh alongside the TIMR_* constants; no local copies.
REQ-030 No sub-module SHALL be used; the interval timer SHALL be a sibling instance wired at the parent (TICK<-PULSE, START_TMR->START_TMR).

Verification
REQ-031 GO at cycle 10, NUM_STEPS=4, LOOP=0, TICK every 20 cycles -> START_TMR at 11, STEP 1,2,3, then DONE with STEP=0 after the 4th TICK, BUSY low.
REQ-032 Same as REQ-031 with LOOP=1 -> after the 4th TICK, STEP=0, STEP_PULSE=1 and START_TMR=1; no DONE.
REQ-033 ABORT and TICK in the same cycle at STEP=2 -> STEP=0, IDLE; a TICK 5 cycles later -> no output activity.
REQ-034 RST_N low mid-WAIT at STEP=3 -> all outputs 0 asynchronously; a TICK after release -> ignored.
REQ-035 SEQ_WDOG_EN with WDOG_CYCLES=50, no TICK after GO -> ERR=1 and IDLE after 50 WAIT cycles; the next GO clears ERR.
REQ-036 GO repeated while BUSY -> no extra START_TMR and STEP unaffected.

Source files
------------

// File: rtl/tick_sequencer_pkg.sv
// Shared sequencer/timer constants: FSM encodings, TIMR_* values and a step helper.
// Pure declarations; no logic, no latency.
// No flow control here; the importing modules own all handshakes.
package tick_sequencer_pkg;

  // Sequencer FSM encodings (2-bit); 2'b11 is illegal and recovers to idle.
  typedef enum logic [1:0] {
    SEQ_IDLE_S = 2'b00,
    SEQ_ARM_S  = 2'b01,
    SEQ_WAIT_S = 2'b10
  } seq_state_e;

  // Interval timer constants shared with the sibling timer instance.
  localparam int         TIMR_CNT_W  = 24;
  localparam logic [1:0] TIMR_IDLE_S = 2'b00;
  localparam logic [1:0] TIMR_RUN_S  = 2'b01;

  // Step width is fixed at 4 bits so NUM_STEPS can reach 16.
  localparam int SEQ_STEP_W = 4;

  // Advance a step index, wrapping to zero after the last step.
  function automatic logic [SEQ_STEP_W-1:0] seq_next_step(
    input logic [SEQ_STEP_W-1:0] step,
    input logic [SEQ_STEP_W-1:0] last
  );
    seq_next_step = (step == last) ? '0 : step + 4'd1;
  endfunction

endpackage

// File: rtl/tick_sequencer.sv
// Tick sequencer: walks NUM_STEPS steps, one per TICK from the interval timer; optional watchdog under SEQ_WDOG_EN.
// Latency: every output is registered, reacting one clock after the input that caused it.
// No backpressure: GO/ABORT/TICK are single-cycle pulses; ABORT has top priority, GO ignored while busy.
module tick_sequencer
  import tick_sequencer_pkg::*;
#(
  parameter int NUM_STEPS   = 8,
  parameter int WDOG_CYCLES = 4194304
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  GO,
  input  logic                  ABORT,
  input  logic                  LOOP,
  input  logic                  TICK,
  output logic                  START_TMR,
  output logic [SEQ_STEP_W-1:0] STEP,
  output logic                  STEP_PULSE,
  output logic                  DONE,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam logic [SEQ_STEP_W-1:0] LAST_STEP = SEQ_STEP_W'(NUM_STEPS - 1);

  // Catch illegal configurations at elaboration time.
  if (NUM_STEPS < 2 || NUM_STEPS > 16) begin : g_bad_num_steps
    $error("tick_sequencer: NUM_STEPS must be in 2..16");
  end
  if (WDOG_CYCLES < 2) begin : g_bad_wdog_cycles
    $error("tick_sequencer: WDOG_CYCLES must be at least 2");
  end

  seq_state_e            state_q, state_d;
  logic [SEQ_STEP_W-1:0] step_q, step_d;
  logic                  start_tmr_q, start_tmr_d;
  logic                  step_pulse_q, step_pulse_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  wdog_trip;
  logic                  at_last;

  assign at_last = (step_q == LAST_STEP);

`ifdef SEQ_WDOG_EN
  localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              err_q, err_d;
  logic              wait_idle;

  // Count consecutive WAIT cycles with no TICK; trip on the WDOG_CYCLES-th one.
  always_comb begin
    wait_idle  = (state_q == SEQ_WAIT_S) && !TICK && !ABORT;
    wdog_trip  = wait_idle && (wdog_cnt_q == WDOG_LAST);
    wdog_cnt_d = '0;
    if (wait_idle && !wdog_trip) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
  end

  // Sticky error: set by a trip, cleared only by reset or an accepted GO.
  always_comb begin
    err_d = err_q;
    if (!ABORT && state_q == SEQ_IDLE_S && GO) begin
      err_d = 1'b0;
    end
    if (wdog_trip) begin
      err_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      err_q      <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign wdog_trip = 1'b0;
  assign ERR       = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SEQ_IDLE_S;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: ABORT wins everything; a GO seen while DONE is still high re-arms via ARM.
  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = SEQ_IDLE_S;
    end else begin
      case (state_q)
        SEQ_IDLE_S: begin
          if (GO) begin
            state_d = done_q ? SEQ_ARM_S : SEQ_WAIT_S;
          end
        end
        SEQ_ARM_S: begin
          state_d = SEQ_WAIT_S;
        end
        SEQ_WAIT_S: begin
          if (wdog_trip) begin
            state_d = SEQ_IDLE_S;
          end else if (TICK && at_last && !LOOP) begin
            state_d = SEQ_IDLE_S;
          end
        end
        default: begin
          state_d = SEQ_IDLE_S;
        end
      endcase
    end
  end

  // Output next-values: strobes default low, STEP holds unless something moves it.
  always_comb begin
    step_d       = step_q;
    start_tmr_d  = 1'b0;
    step_pulse_d = 1'b0;
    done_d       = 1'b0;
    if (ABORT) begin
      step_d = '0;
    end else begin
      case (state_q)
        SEQ_IDLE_S: begin
          if (GO) begin
            step_d      = '0;
            start_tmr_d = 1'b1;
          end
        end
        SEQ_ARM_S: begin
          // The timer was armed on entry to ARM; nothing more to issue here.
          step_d = step_q;
        end
        SEQ_WAIT_S: begin
          if (wdog_trip) begin
            step_d = '0;
          end else if (TICK) begin
            step_d = seq_next_step(step_q, LAST_STEP);
            if (!at_last || LOOP) begin
              step_pulse_d = 1'b1;
              start_tmr_d  = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        default: begin
          step_d = '0;
        end
      endcase
    end
    busy_d = (state_d != SEQ_IDLE_S);
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_q       <= '0;
      start_tmr_q  <= 1'b0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      step_q       <= step_d;
      start_tmr_q  <= start_tmr_d;
      step_pulse_q <= step_pulse_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign STEP       = step_q;
  assign START_TMR  = start_tmr_q;
  assign STEP_PULSE = step_pulse_q;
  assign DONE       = done_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer with NUM_STEPS=4, WDOG_CYCLES=50.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
// Watchdog steps are compiled in only when SEQ_WDOG_EN is defined.
module tb_tick_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       GO = 1'b0;
  logic       ABORT = 1'b0;
  logic       LOOP = 1'b0;
  logic       TICK = 1'b0;
  logic       START_TMR;
  logic [3:0] STEP;
  logic       STEP_PULSE;
  logic       DONE;
  logic       BUSY;
  logic       ERR;

  int n_total = 0;
  int n_fail  = 0;

  tick_sequencer #(
    .NUM_STEPS  (4),
    .WDOG_CYCLES(50)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .GO        (GO),
    .ABORT     (ABORT),
    .LOOP      (LOOP),
    .TICK      (TICK),
    .START_TMR (START_TMR),
    .STEP      (STEP),
    .STEP_PULSE(STEP_PULSE),
    .DONE      (DONE),
    .BUSY      (BUSY),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] step, input logic start,
                          input logic pulse, input logic done, input logic busy, input logic err);
    chk({tag, ".step"},  {28'd0, STEP}, {28'd0, step});
    chk({tag, ".start"}, {31'd0, START_TMR}, {31'd0, start});
    chk({tag, ".pulse"}, {31'd0, STEP_PULSE}, {31'd0, pulse});
    chk({tag, ".done"},  {31'd0, DONE}, {31'd0, done});
    chk({tag, ".busy"},  {31'd0, BUSY}, {31'd0, busy});
    chk({tag, ".err"},   {31'd0, ERR}, {31'd0, err});
  endtask

  task automatic pulse_go();
    GO = 1'b1; cyc(); GO = 1'b0;
  endtask

  task automatic pulse_tick();
    TICK = 1'b1; cyc(); TICK = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    chk_outs("reset", 4'd0, 0, 0, 0, 0, 0);
    RST_N = 1'b1;
    idle(8);

    // One-shot sequence, LOOP=0, ticks 20 cycles apart
    pulse_go();
    chk_outs("go", 4'd0, 1, 0, 0, 1, 0);
    cyc();
    chk_outs("go+1", 4'd0, 0, 0, 0, 1, 0);
    pulse_go();   // GO while busy is ignored
    chk_outs("go_busy", 4'd0, 0, 0, 0, 1, 0);
    idle(16);
    pulse_tick();
    chk_outs("t1", 4'd1, 1, 1, 0, 1, 0);
    cyc();
    chk_outs("t1+1", 4'd1, 0, 0, 0, 1, 0);
    idle(18);
    pulse_tick();
    chk_outs("t2", 4'd2, 1, 1, 0, 1, 0);
    idle(19);
    pulse_tick();
    chk_outs("t3", 4'd3, 1, 1, 0, 1, 0);
    idle(19);
    pulse_tick();
    chk_outs("t4_done", 4'd0, 0, 0, 1, 0, 0);
    cyc();
    chk_outs("done+1", 4'd0, 0, 0, 0, 0, 0);

    // Looping sequence
    LOOP = 1'b1;
    pulse_go();
    chk_outs("loop_go", 4'd0, 1, 0, 0, 1, 0);
    repeat (3) begin idle(5); pulse_tick(); end
    chk_outs("loop_t3", 4'd3, 1, 1, 0, 1, 0);
    idle(5);
    pulse_tick();
    chk_outs("loop_wrap", 4'd0, 1, 1, 0, 1, 0);
    idle(5);
    pulse_tick();
    chk_outs("loop_t1", 4'd1, 1, 1, 0, 1, 0);
    LOOP = 1'b0;

    // ABORT beats a simultaneous TICK at STEP=2; a stray TICK later is ignored
    idle(5);
    pulse_tick();
    chk_outs("ab_pre", 4'd2, 1, 1, 0, 1, 0);
    idle(3);
    ABORT = 1'b1; TICK = 1'b1; cyc(); ABORT = 1'b0; TICK = 1'b0;
    chk_outs("abort", 4'd0, 0, 0, 0, 0, 0);
    idle(4);
    pulse_tick();
    chk_outs("stray_tick", 4'd0, 0, 0, 0, 0, 0);
    cyc();
    chk_outs("stray_tick+1", 4'd0, 0, 0, 0, 0, 0);

    // ABORT beats a simultaneous GO in idle
    GO = 1'b1; ABORT = 1'b1; cyc(); GO = 1'b0; ABORT = 1'b0;
    chk_outs("abort_go", 4'd0, 0, 0, 0, 0, 0);

    // GO in the same cycle DONE is visible re-arms through ARM
    pulse_go();
    repeat (4) begin idle(3); pulse_tick(); end
    chk_outs("rearm_done", 4'd0, 0, 0, 1, 0, 0);
    pulse_go();
    chk_outs("rearm_arm", 4'd0, 1, 0, 0, 1, 0);
    cyc();
    chk_outs("rearm_wait", 4'd0, 0, 0, 0, 1, 0);
    idle(2);
    pulse_tick();
    chk_outs("rearm_t1", 4'd1, 1, 1, 0, 1, 0);

    // Asynchronous reset mid-WAIT at STEP=3
    idle(2); pulse_tick();
    idle(2); pulse_tick();
    chk_outs("rst_pre", 4'd3, 1, 1, 0, 1, 0);
    #2 RST_N = 1'b0;
    #1;
    chk_outs("rst_async", 4'd0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();
    pulse_tick();
    chk_outs("rst_tick", 4'd0, 0, 0, 0, 0, 0);
    idle(3);
    chk_outs("rst_quiet", 4'd0, 0, 0, 0, 0, 0);

`ifdef SEQ_WDOG_EN
    // Watchdog: 50 tickless WAIT cycles trip ERR; next GO clears it
    pulse_go();
    idle(49);
    chk_outs("wdog_49", 4'd0, 0, 0, 0, 1, 0);
    cyc();
    chk_outs("wdog_trip", 4'd0, 0, 0, 0, 0, 1);
    idle(3);
    chk_outs("wdog_sticky", 4'd0, 0, 0, 0, 0, 1);
    pulse_go();
    chk_outs("wdog_clear", 4'd0, 1, 0, 0, 1, 0);
    ABORT = 1'b1; cyc(); ABORT = 1'b0;
    chk_outs("wdog_abort", 4'd0, 0, 0, 0, 0, 0);
`else
    // Without the watchdog a long tickless WAIT stays busy and ERR stays low
    pulse_go();
    idle(60);
    chk_outs("nowdog_wait", 4'd0, 0, 0, 0, 1, 0);
    ABORT = 1'b1; cyc(); ABORT = 1'b0;
    chk_outs("nowdog_abort", 4'd0, 0, 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
